kbd_event_fifo: RTL and testbench
=================================

KBD_EVENT_FIFO -- requirements
Module: kbd_event_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two, >=2).
REQ-002 The block SHALL have parameter DELAY_CYC, default 12500000, meaning the held-key cycles before the first repeat (0.5 s at 25 MHz).
REQ-003 The block SHALL have parameter RATE_CYC, default 2500000, meaning the cycles between repeats (10 Hz).
REQ-004 The block SHALL have port clk25  in  1  meaning 25 MHz system clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n  in  1  meaning synchronous, active-low reset.
REQ-006 The block SHALL have port ascii  in  8  meaning the decoded key code from the keyboard decoder (8'h00 = no key), asynchronous to clk25.
REQ-007 The block SHALL have port rd_en  in  1  meaning pop request from the consumer.
REQ-008 The block SHALL have port rd_data  out  8  meaning the head entry (show-ahead), valid while empty=0.
REQ-009 The block SHALL have ports empty  out  1 and full  out  1, meaning the FIFO status flags.
REQ-010 The block SHALL have port count  out  $clog2(DEPTH)+1  meaning the number of stored entries.
REQ-011 The block SHALL have port overflow  out  1  meaning sticky dropped-event flag.
REQ-012 The block SHALL have port clr_ovf  in  1  meaning clear for overflow.

Function
REQ-013 The block SHALL sample ascii through two flops (s1, s2) and SHALL load qualified code_q only when s1==s2 in the same cycle.
REQ-014 A press event SHALL occur when code_q changes from 8'h00 to non-zero, or from one non-zero value to a different non-zero value; the event value SHALL be the new code_q.
REQ-015 A change of code_q to 8'h00 (release) SHALL generate no event.
REQ-016 An ascii value held stable from edge N SHALL be written so that empty=0 and rd_data=value after edge N+4.
REQ-017 The key FSM SHALL use the states IDLE (code_q==0), HELD (counting DELAY_CYC) and REPEAT (counting RATE_CYC).
REQ-018 The FSM SHALL move IDLE->HELD on a press and HELD->REPEAT with a repeat event after DELAY_CYC cycles in HELD; in REPEAT it SHALL issue a repeat event every RATE_CYC cycles.
REQ-019 In any state, release SHALL force IDLE, and a press of a different code SHALL force HELD with the counter cleared.
REQ-020 On push with full=0, the block SHALL write at wr_ptr, increment wr_ptr and count.
REQ-021 On push with full=1 and no pop, the block SHALL drop the event and set overflow to 1.
REQ-022 On rd_en with empty=0, the block SHALL advance rd_ptr and decrement count; rd_en while empty SHALL be ignored.
REQ-023 Simultaneous push and pop when full SHALL accept both, leave count unchanged and not set overflow.
REQ-024 Simultaneous push and pop when empty SHALL ignore the pop and accept the push.
REQ-025 Pointers SHALL wrap modulo DEPTH; full SHALL equal (count==DEPTH) and empty SHALL equal (count==0).
REQ-026 overflow SHALL be cleared by clr_ovf; if clr_ovf coincides with a new drop, set SHALL win.

Reset
REQ-027 While rst_n=0 at a clk25 edge, the block SHALL reset s1, s2 and code_q to 8'h00, the FSM to IDLE, counters, pointers and count to 0, empty to 1, full to 0, overflow to 0 and rd_data to 8'h00.
REQ-028 Reset mid-operation SHALL discard all stored entries.
REQ-029 A key still held when reset is released SHALL produce one press event once it qualifies.

Configuration
REQ-030 With macro KBD_REPEAT_EN defined, the REPEAT state and both repeat counters SHALL be built.
REQ-031 Without KBD_REPEAT_EN, the FSM SHALL have only IDLE and HELD, no counters, and exactly one event per press; DELAY_CYC and RATE_CYC SHALL be unused.

Structure
REQ-032 Package kbd_pkg SHALL hold KEY_NONE=8'h00, the FSM state typedef (IDLE/HELD/REPEAT) and the default DEPTH/DELAY_CYC/RATE_CYC constants.
REQ-033 Storage and pointers SHALL form sub-module kbd_sync_fifo (show-ahead, push/pop/count/full/empty); the qualifier and FSM SHALL live in kbd_event_fifo.

Verification (DELAY_CYC=20, RATE_CYC=5 for sim)
REQ-034 Single press: ascii=8'h61 held 10 cycles then 8'h00 -> one entry 8'h61, empty=0 after edge N+4; rd_en -> empty=1.
REQ-035 Glitch: ascii=8'h62 for one cycle only -> no entry, count=0.
REQ-036 Repeat (KBD_REPEAT_EN): 8'h41 held 40 cycles -> entries at about +4, +24, +29, +34, +39 (5 x 8'h41); without the macro -> 1 entry.
REQ-037 Overflow: 17 distinct presses with no reads -> count=16, full=1, overflow=1, entries 1..16 intact; clr_ovf -> overflow=0.
REQ-038 Full push+pop: full FIFO, a press coinciding with rd_en -> count stays 16, overflow=0, the new code is at the tail.
REQ-039 Reset mid-run: 5 entries stored, rst_n=0 for 1 cycle -> count=0, empty=1, rd_data=8'h00, FSM in IDLE.

Source files
------------

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared key codes, key FSM state type and default sizing constants
// for the keyboard event FIFO.
package kbd_pkg;

  localparam logic [7:0] KEY_NONE = 8'h00;

  localparam int unsigned DEF_DEPTH     = 16;
  localparam int unsigned DEF_DELAY_CYC = 12500000;
  localparam int unsigned DEF_RATE_CYC  = 2500000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } key_state_e;

endpackage

// File: rtl/kbd_sync_fifo.sv
// kbd_sync_fifo: show-ahead synchronous FIFO; a push into a full FIFO is only
// accepted when a pop frees a slot in the same cycle, otherwise o_drop flags it.
module kbd_sync_fifo import kbd_pkg::*; #(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk25,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_pushData,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdData,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;

  logic w_empty;
  logic w_full;
  logic w_doPush;
  logic w_doPop;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == (AW+1)'(DEPTH));
  assign w_doPop  = i_pop && !w_empty;
  // When full, a pop is always legal, so it makes room for the push.
  assign w_doPush = i_push && (!w_full || i_pop);

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk25) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_pushData;
  end

  assign o_rdData = w_empty ? '0 : r_mem[r_rdPtr];
  assign o_empty  = w_empty;
  assign o_full   = w_full;
  assign o_count  = r_count;
  assign o_drop   = i_push && !w_doPush;

endmodule

// File: rtl/kbd_event_fifo.sv
// kbd_event_fifo: qualifies an asynchronous key code, turns presses into events
// and queues them; define KBD_REPEAT_EN to add the auto-repeat state and counters.
module kbd_event_fifo import kbd_pkg::*; #(
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned DELAY_CYC = DEF_DELAY_CYC,
  parameter int unsigned RATE_CYC  = DEF_RATE_CYC
) (
  input  logic                   clk25,
  input  logic                   rst_n,
  input  logic [7:0]             ascii,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clr_ovf
);

`ifdef KBD_REPEAT_EN
  localparam int unsigned DLY_W  = $clog2(DELAY_CYC + 1);
  localparam int unsigned RATE_W = $clog2(RATE_CYC + 1);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(DELAY_CYC - 1);
  localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(RATE_CYC - 1);

  logic [DLY_W-1:0]  r_delayCnt;
  logic [RATE_W-1:0] r_rateCnt;
`endif

  logic [7:0]  r_s1;
  logic [7:0]  r_s2;
  logic [7:0]  r_codeQ;
  key_state_e  r_state;
  logic        r_push;
  logic [7:0]  r_pushData;
  logic        r_overflow;

  logic        w_load;
  logic        w_press;
  logic        w_drop;

  // A code is trusted only once both synchroniser stages agree on it.
  assign w_load  = (r_s1 == r_s2) && (r_s2 != r_codeQ);
  assign w_press = w_load && (r_s2 != KEY_NONE);

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      r_s1    <= KEY_NONE;
      r_s2    <= KEY_NONE;
      r_codeQ <= KEY_NONE;
    end else begin
      r_s1 <= ascii;
      r_s2 <= r_s1;
      if (w_load) r_codeQ <= r_s2;
    end
  end

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_push     <= 1'b0;
      r_pushData <= KEY_NONE;
`ifdef KBD_REPEAT_EN
      r_delayCnt <= '0;
      r_rateCnt  <= '0;
`endif
    end else begin
      r_push <= 1'b0;
      if (w_load) begin
        r_state <= w_press ? HELD : IDLE;
        r_push  <= w_press;
        if (w_press) r_pushData <= r_s2;
`ifdef KBD_REPEAT_EN
        r_delayCnt <= '0;
        r_rateCnt  <= '0;
`endif
      end else begin
        case (r_state)
`ifdef KBD_REPEAT_EN
          HELD: begin
            if (r_delayCnt == DLY_LAST) begin
              r_state    <= REPEAT;
              r_push     <= 1'b1;
              r_pushData <= r_codeQ;
              r_delayCnt <= '0;
              r_rateCnt  <= '0;
            end else begin
              r_delayCnt <= r_delayCnt + 1'b1;
            end
          end
          REPEAT: begin
            if (r_rateCnt == RATE_LAST) begin
              r_push     <= 1'b1;
              r_pushData <= r_codeQ;
              r_rateCnt  <= '0;
            end else begin
              r_rateCnt <= r_rateCnt + 1'b1;
            end
          end
`endif
          default: r_state <= r_state;
        endcase
      end
    end
  end

  kbd_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk25      (clk25),
    .rst_n      (rst_n),
    .i_push     (r_push),
    .i_pushData (r_pushData),
    .i_pop      (rd_en),
    .o_rdData   (rd_data),
    .o_empty    (empty),
    .o_full     (full),
    .o_count    (count),
    .o_drop     (w_drop)
  );

  // A drop in the same cycle as a clear must leave the flag set.
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;

endmodule

// File: tb/tb_kbd_event_fifo.sv
// tb_kbd_event_fifo: directed and randomized key stimulus checked every cycle
// against a queue-based reference of key events and FIFO contents.
module tb_kbd_event_fifo;
  import kbd_pkg::*;

  localparam int DEPTH = 16;
  localparam int DELAY = 20;
  localparam int RATE  = 5;

  logic       clk25 = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ascii = 8'h00;
  logic       rd_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;

  kbd_event_fifo #(
    .DEPTH     (DEPTH),
    .DELAY_CYC (DELAY),
    .RATE_CYC  (RATE)
  ) dut (
    .clk25    (clk25),
    .rst_n    (rst_n),
    .ascii    (ascii),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #20 clk25 = ~clk25;

  int vecCount  = 0;
  int missCount = 0;

  // Reference: the event queue, the sticky flag, the last two samples of ascii,
  // the qualified key, how long it has been held, and an event awaiting storage.
  logic [7:0] mQ[$];
  bit         mOvf     = 1'b0;
  logic [7:0] mSmp1    = 8'h00;
  logic [7:0] mSmp2    = 8'h00;
  logic [7:0] mCode    = 8'h00;
  int         mAge     = 0;
  bit         mPend    = 1'b0;
  logic [7:0] mPendVal = 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, wanted %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic modelEdge();
    bit         drop;
    bit         newPend;
    logic [7:0] newVal;
    drop    = 1'b0;
    newPend = 1'b0;
    newVal  = 8'h00;
    if (!rst_n) begin
      mQ.delete();
      mOvf  = 1'b0;
      mSmp1 = 8'h00;
      mSmp2 = 8'h00;
      mCode = 8'h00;
      mAge  = 0;
      mPend = 1'b0;
      return;
    end
    if (rd_en && mQ.size() > 0) void'(mQ.pop_front());
    if (mPend) begin
      if (mQ.size() < DEPTH) mQ.push_back(mPendVal);
      else drop = 1'b1;
    end
    if (clr_ovf) mOvf = 1'b0;
    if (drop) mOvf = 1'b1;
    if (mSmp1 == mSmp2 && mSmp2 != mCode) begin
      mCode = mSmp2;
      mAge  = 0;
      if (mCode != KEY_NONE) begin
        newPend = 1'b1;
        newVal  = mCode;
      end
    end else if (mCode != KEY_NONE) begin
      mAge++;
`ifdef KBD_REPEAT_EN
      if (mAge == DELAY || (mAge > DELAY && (mAge - DELAY) % RATE == 0)) begin
        newPend = 1'b1;
        newVal  = mCode;
      end
`endif
    end
    mSmp2    = mSmp1;
    mSmp1    = ascii;
    mPend    = newPend;
    mPendVal = newVal;
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic rd, input logic clr, input logic rstN);
    ascii   = a;
    rd_en   = rd;
    clr_ovf = clr;
    rst_n   = rstN;
    @(posedge clk25);
    modelEdge();
    #1;
    checkOutput("count", count, mQ.size());
    checkOutput("empty", empty, mQ.size() == 0);
    checkOutput("full", full, mQ.size() == DEPTH);
    checkOutput("overflow", overflow, mOvf);
    checkOutput("rd_data", rd_data, (mQ.size() > 0) ? mQ[0] : 8'h00);
  endtask

  task automatic holdKey(input logic [7:0] a, input int n);
    for (int i = 0; i < n; i++) applyStimulus(a, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] code;
    int         hold;
    $display("[TB] start, repeat %s", `ifdef KBD_REPEAT_EN "enabled" `else "disabled" `endif);

    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("resetEmpty", empty, 1);
    checkOutput("resetData", rd_data, 8'h00);
    holdKey(8'h00, 4);

    // Single press: visible four edges after the code appears
    holdKey(8'h61, 3);
    checkOutput("pressNotYet", empty, 1);
    holdKey(8'h61, 1);
    checkOutput("pressSeen", empty, 0);
    checkOutput("pressData", rd_data, 8'h61);
    holdKey(8'h61, 6);
    holdKey(8'h00, 6);
    checkOutput("singleCount", count, 1);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
    checkOutput("popEmpty", empty, 1);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);

    // One-cycle glitch must not qualify
    holdKey(8'h62, 1);
    holdKey(8'h00, 8);
    checkOutput("glitchCount", count, 0);

    // Held key: repeats only when the feature is built
    holdKey(8'h41, 40);
    holdKey(8'h00, 8);
`ifdef KBD_REPEAT_EN
    checkOutput("repeatCount", count, 5);
`else
    checkOutput("repeatCount", count, 1);
`endif
    for (int i = 0; i < 6; i++) applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);

    // Seventeen distinct presses into a sixteen-entry FIFO
    for (int i = 0; i < 17; i++) holdKey(8'h30 + 8'(i), 3);
    holdKey(8'h00, 8);
    checkOutput("ovfCount", count, 16);
    checkOutput("ovfFull", full, 1);
    checkOutput("ovfFlag", overflow, 1);
    checkOutput("ovfHead", rd_data, 8'h30);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1);
    checkOutput("ovfCleared", overflow, 0);

    // Press landing on a full FIFO together with a pop
    for (int i = 0; i < 12 && !mPend; i++) applyStimulus(8'h5A, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h5A, 1'b1, 1'b0, 1'b1);
    holdKey(8'h00, 6);
    checkOutput("pushPopCount", count, 16);
    checkOutput("pushPopOvf", overflow, 0);
    for (int i = 0; i < 15; i++) applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
    checkOutput("pushPopTail", rd_data, 8'h5A);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);

    // Reset with entries stored, then a key held across reset
    for (int i = 0; i < 5; i++) holdKey(8'h70 + 8'(i), 3);
    holdKey(8'h00, 6);
    checkOutput("preResetCount", count, 5);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("rstCount", count, 0);
    checkOutput("rstEmpty", empty, 1);
    checkOutput("rstData", rd_data, 8'h00);
    holdKey(8'h00, 10);
    checkOutput("rstIdle", count, 0);
    holdKey(8'h77, 3);
    applyStimulus(8'h77, 1'b0, 1'b0, 1'b0);
    holdKey(8'h77, 8);
    holdKey(8'h00, 6);
    checkOutput("heldThroughReset", count, 1);
    checkOutput("heldThroughData", rd_data, 8'h77);

    // Random keys, reads, clears and the occasional reset
    for (int seg = 0; seg < 120; seg++) begin
      case ($urandom_range(0, 5))
        0:       code = 8'h00;
        1:       code = 8'h41;
        2:       code = 8'h42;
        3:       code = 8'h43;
        default: code = 8'($urandom_range(1, 255));
      endcase
      hold = $urandom_range(1, 30);
      for (int i = 0; i < hold; i++)
        applyStimulus(code, ($urandom % 4) == 0, ($urandom % 16) == 0, ($urandom % 400) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
